// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: opcode, funct and ALU codes, FSM states and the control word
package multicycle_control_unit_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;
    typedef struct packed {
        logic       memreq;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: R-type funct to ALUControl, flagging functs the datapath cannot execute
module alu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal
);
    always_comb begin
        alu_control = funct == FN_SUB ? ALU_SUB :
                      funct == FN_AND ? ALU_AND :
                      funct == FN_OR  ? ALU_OR  : ALU_ADD;
        illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR});
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/execute/memory/writeback sequencer for the multi-cycle MIPS datapath
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       ZeroFlag,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       IllegalOp
);
    state_t     state, next;
    ctrl_t      c, g;
    logic [2:0] dec_alu;
    logic       dec_illegal;

    alu_decoder u_alu_decoder (
        .funct       (Funct),
        .alu_control (dec_alu),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= next;
    end

    always_comb begin
        next         = state;
        c            = '0;
        c.alucontrol = ALU_ADD;
        case (state)
            S_FETCH: begin
                c.memreq  = 1'b1;
                c.alusrcb = 2'b01;
                c.irwrite = MemReady;
                c.pcwrite = MemReady;
                next      = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_EXECUTE;
                    OP_BEQ:       next = S_BRANCH;
                    OP_ADDI:      next = S_ADDIEXEC;
                    OP_J:         next = S_JUMP;
                    default: begin
                        c.illegal = 1'b1;
                        next      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                next      = Opcode == OP_LW ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                c.memreq = 1'b1;
                c.iord   = 1'b1;
                next     = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                next       = S_FETCH;
            end
            S_MEMWRITE: begin
                c.memreq   = 1'b1;
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
                next       = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                c.alusrca    = 1'b1;
                c.alucontrol = dec_alu;
                c.illegal    = dec_illegal;
                next         = dec_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                next       = S_FETCH;
            end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
                next         = S_FETCH;
            end
            S_ADDIEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                c.regwrite = 1'b1;
                next       = S_FETCH;
            end
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
                next      = S_FETCH;
            end
            default: next = S_FETCH;
        endcase
    end

    // Gating by reset_n makes every output drop the instant reset asserts, aborting any pending write.
    assign g          = reset_n ? c : '0;
    assign MemReq     = g.memreq;
    assign MemWrite   = g.memwrite;
    assign IorD       = g.iord;
    assign IRWrite    = g.irwrite;
    assign PCEn       = g.pcwrite | (g.branch & ZeroFlag);
    assign PCSrc      = g.pcsrc;
    assign ALUSrcA    = g.alusrca;
    assign ALUSrcB    = g.alusrcb;
    assign ALUControl = g.alucontrol;
    assign RegDst     = g.regdst;
    assign MemtoReg   = g.memtoreg;
    assign RegWrite   = g.regwrite;
    assign IllegalOp  = g.illegal;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-instruction vector table checked through an expected-result queue,
// plus reset and mid-instruction abort sequences
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] Opcode = '0, Funct = '0;
    logic       ZeroFlag = 1'b0, MemReady = 1'b1;
    logic       MemReq, MemWrite, IorD, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, IllegalOp;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;
    logic [16:0] outs;
    int checks = 0, failures = 0;

    typedef struct packed {
        int         cycles, rw, mw, io, pcen, ill, irw;
        logic       rd, m2r;
        logic [2:0] alu;
        logic [1:0] pcsrc;
    } res_t;
    typedef struct packed {
        logic [5:0] op, fn;
        logic       zero;
        int         w;
        res_t       exp;
    } vec_t;

    vec_t vt[14];
    res_t sb[$];

    multicycle_control_unit dut (
        .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Funct(Funct), .ZeroFlag(ZeroFlag),
        .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp)
    );

    assign outs = {MemReq, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                   ALUControl, RegDst, MemtoReg, RegWrite, IllegalOp};

    always #5 clk = ~clk;

    function automatic vec_t v(logic [5:0] op, logic [5:0] fn, logic z, int w, int cyc, int rw,
                               logic rd, logic m2r, int mw, int io, int pcen, int ill,
                               logic [2:0] alu, logic [1:0] pcsrc);
        vec_t r;
        r.op = op; r.fn = fn; r.zero = z; r.w = w;
        r.exp.cycles = cyc; r.exp.rw = rw; r.exp.mw = mw; r.exp.io = io; r.exp.pcen = pcen;
        r.exp.ill = ill; r.exp.irw = 1; r.exp.rd = rd; r.exp.m2r = m2r;
        r.exp.alu = alu; r.exp.pcsrc = pcsrc;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered at (or just after) a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(int i);
        res_t o, e;
        int   cyc = 0, waited = 0;
        o = '0; o.alu = 3'b111; o.pcsrc = 2'b11;
        Opcode = vt[i].op; Funct = vt[i].fn; ZeroFlag = vt[i].zero;
        sb.push_back(vt[i].exp);
        forever begin
            if (cyc > 0 && MemReq && !IorD) break;
            if (cyc >= 20) begin
                checks++; failures++;
                $display("FAIL v%0d.timeout: got %0d cycles expected %0d", i, cyc, vt[i].exp.cycles);
                break;
            end
            MemReady = (MemReq && IorD && waited < vt[i].w) ? 1'b0 : 1'b1;
            if (!MemReady) waited++;
            #1;
            if (RegWrite) begin o.rw++; o.rd = RegDst; o.m2r = MemtoReg; end
            if (MemReq && MemWrite) o.mw++;
            if (MemReq && IorD) o.io++;
            if (PCEn) o.pcen++;
            if (IllegalOp) o.ill++;
            if (IRWrite) o.irw++;
            if (cyc == 2) begin o.alu = ALUControl; o.pcsrc = PCSrc; end
            cyc++;
            @(negedge clk);
        end
        o.cycles = cyc;
        e = sb.pop_front();
        check($sformatf("v%0d.cycles", i), o.cycles, e.cycles);
        check($sformatf("v%0d.regwrite", i), o.rw, e.rw);
        check($sformatf("v%0d.regdst", i), int'(o.rd), int'(e.rd));
        check($sformatf("v%0d.memtoreg", i), int'(o.m2r), int'(e.m2r));
        check($sformatf("v%0d.memwrite", i), o.mw, e.mw);
        check($sformatf("v%0d.iord_req", i), o.io, e.io);
        check($sformatf("v%0d.pcen", i), o.pcen, e.pcen);
        check($sformatf("v%0d.illegal", i), o.ill, e.ill);
        check($sformatf("v%0d.irwrite", i), o.irw, e.irw);
        check($sformatf("v%0d.alu_c3", i), int'(o.alu), int'(e.alu));
        check($sformatf("v%0d.pcsrc_c3", i), int'(o.pcsrc), int'(e.pcsrc));
    endtask

    initial begin
        //        op        fn        z  w cyc rw rd m2r mw io pcen ill alu     pcsrc
        vt[0]  = v(6'h00, 6'b100000, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 3'b010, 2'b00);
        vt[1]  = v(6'h00, 6'b100010, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 3'b011, 2'b00);
        vt[2]  = v(6'h00, 6'b100100, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 3'b000, 2'b00);
        vt[3]  = v(6'h00, 6'b100101, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 3'b001, 2'b00);
        vt[4]  = v(6'h00, 6'b101010, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 3'b010, 2'b00);
        vt[5]  = v(6'b100011, 6'h00, 0, 0, 5, 1, 0, 1, 0, 1, 1, 0, 3'b010, 2'b00);
        vt[6]  = v(6'b100011, 6'h00, 0, 2, 7, 1, 0, 1, 0, 3, 1, 0, 3'b010, 2'b00);
        vt[7]  = v(6'b101011, 6'h00, 0, 0, 4, 0, 0, 0, 1, 1, 1, 0, 3'b010, 2'b00);
        vt[8]  = v(6'b101011, 6'h00, 0, 1, 5, 0, 0, 0, 2, 2, 1, 0, 3'b010, 2'b00);
        vt[9]  = v(6'b000100, 6'h00, 1, 0, 3, 0, 0, 0, 0, 0, 2, 0, 3'b011, 2'b01);
        vt[10] = v(6'b000100, 6'h00, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 3'b011, 2'b01);
        vt[11] = v(6'b001000, 6'h00, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 3'b010, 2'b00);
        vt[12] = v(6'b000010, 6'h00, 0, 0, 3, 0, 0, 0, 0, 0, 2, 0, 3'b010, 2'b10);
        vt[13] = v(6'b111111, 6'h00, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 3'b111, 2'b11);

        Opcode = 6'b101011; ZeroFlag = 1'b1; MemReady = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs_zero", int'(outs), 0);
        MemReady = 1'b0;
        reset_n = 1'b1;
        #1;
        check("post_reset_memreq", int'(MemReq), 1);
        check("post_reset_alusrcb", int'(ALUSrcB), 1);
        check("fetch_stall_irwrite", int'(IRWrite), 0);
        @(negedge clk);
        check("fetch_hold_memreq", int'(MemReq && !IorD), 1);
        check("fetch_hold_pcen", int'(PCEn), 0);

        for (int i = 0; i < 14; i++) run_instr(i);

        // Abort a store stalled in MEMWRITE with reset.
        Opcode = 6'b101011; MemReady = 1'b1;
        for (int n = 0; n < 10 && !(MemReq && IorD); n++) @(negedge clk);
        MemReady = 1'b0;
        #1;
        check("memwrite_before_abort", int'(MemWrite), 1);
        reset_n = 1'b0;
        #1;
        check("abort_outs_zero", int'(outs), 0);
        @(negedge clk);
        check("abort_held_zero", int'(outs), 0);
        reset_n = 1'b1;
        #1;
        check("restart_memreq", int'(MemReq), 1);
        check("restart_memwrite", int'(MemWrite), 0);
        check("restart_iord", int'(IorD), 0);
        run_instr(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
